// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and its neighbours on the memory path.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_prio_starve.sv
// Fixed-priority grant (LSU first) with a starvation guard for the IFU.
module arb_prio_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic ifu_req,
    input  logic lsu_req,
    output logic grant_ifu,
    output logic grant_lsu
);

    logic [7:0] starve_cnt;
    logic       contested;
    logic       forced;

    // LSU wins contention unless the IFU has lost STARVE_LIMIT times in a row.
    always_comb begin
        contested = ifu_req & lsu_req;
        forced    = contested && (starve_cnt == 8'(STARVE_LIMIT));
        grant_lsu = arb_en & lsu_req & ~forced;
        grant_ifu = arb_en & ifu_req & (~lsu_req | forced);
    end

    // Count contested LSU wins; any IFU grant clears the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
        end else if (grant_ifu) begin
            starve_cnt <= 8'd0;
        end else if (grant_lsu && contested && (starve_cnt != 8'hFF)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err_unexp_rsp
);

    arb_state_t          state;
    arb_state_t          state_next;
    owner_t              owner;
    logic                grant_ifu;
    logic                grant_lsu;
    logic                arb_en;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic                rsp_ifu;
    logic                rsp_lsu;

    // Arbitration is only live in IDLE and never while reset is held.
    assign arb_en = (state == ST_IDLE) & rst_n;

    arb_prio_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .ifu_req   (ifu_req_valid),
        .lsu_req   (lsu_req_valid),
        .grant_ifu (grant_ifu),
        .grant_lsu (grant_lsu)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, hand to memory, wait for the single response.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_ifu || grant_lsu) state_next = ST_REQ;
            ST_REQ:  if (mem_req_ready)          state_next = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid)          state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // Capture the winning request; IFU fetches are always unmasked reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (grant_lsu) begin
            owner   <= OWN_LSU;
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
        end else if (grant_ifu) begin
            owner   <= OWN_IFU;
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end
    end

    // Any response outside WAIT (including one arriving with the accept) is sticky-flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexp_rsp <= 1'b0;
        end else if (mem_rsp_valid && (state != ST_WAIT)) begin
            err_unexp_rsp <= 1'b1;
        end
    end

    // Upstream handshakes and zero-latency response steering to the owner.
    always_comb begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        mem_req_valid = (state == ST_REQ);
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        rsp_ifu       = (state == ST_WAIT) && (owner == OWN_IFU) && mem_rsp_valid;
        rsp_lsu       = (state == ST_WAIT) && (owner == OWN_LSU) && mem_rsp_valid;
        ifu_rsp_valid = rsp_ifu;
        lsu_rsp_valid = rsp_lsu;
        ifu_rdata     = rsp_ifu ? mem_rdata : '0;
        lsu_rdata     = rsp_lsu ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;

    typedef struct {
        bit          is_lsu;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        err_unexp_rsp;

    int   assertions = 0;
    int   failures   = 0;
    rsp_t exp_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: every upstream response is popped from the scoreboard and compared.
    always @(negedge clk) begin
        #2;
        if (ifu_rsp_valid === 1'b1 || lsu_rsp_valid === 1'b1) begin
            assertions++;
            if (ifu_rsp_valid === 1'b1 && lsu_rsp_valid === 1'b1) begin
                failures++;
                $display("[TB] FAIL rsp_both: got both rsp_valid high, expected one at %0t", $time);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL rsp_unexpected: got ifu=%0b lsu=%0b, expected none at %0t",
                         ifu_rsp_valid, lsu_rsp_valid, $time);
            end else begin
                rsp_t e;
                logic [31:0] got;
                e   = exp_q.pop_front();
                got = e.is_lsu ? lsu_rdata : ifu_rdata;
                if ((lsu_rsp_valid === 1'b1) != e.is_lsu || got !== e.data) begin
                    failures++;
                    $display("[TB] FAIL rsp_data: got lsu=%0b data 0x%0h, expected lsu=%0b data 0x%0h at %0t",
                             lsu_rsp_valid, got, e.is_lsu, e.data, $time);
                end
            end
        end
    end

    // Drive one request (or a contested pair), serve it from memory and queue the expected response.
    task automatic applyStimulus(input bit ifu_v, input bit lsu_v,
                                 input logic [31:0] iaddr, input logic [31:0] laddr,
                                 input bit wen, input logic [31:0] wdata, input logic [3:0] wmask,
                                 input int stall, input int delay, input logic [31:0] rdata,
                                 input bit exp_lsu);
        rsp_t e;
        logic [31:0] ea;
        ifu_req_valid = ifu_v;
        lsu_req_valid = lsu_v;
        ifu_addr  = iaddr;
        lsu_addr  = laddr;
        lsu_wen   = wen;
        lsu_wdata = wdata;
        lsu_wmask = wmask;
        #1;
        checkOutput("ifu_req_ready", {63'd0, ifu_req_ready}, {63'd0, !exp_lsu});
        checkOutput("lsu_req_ready", {63'd0, lsu_req_ready}, {63'd0, exp_lsu});
        tick();
        if (exp_lsu) lsu_req_valid = 1'b0;
        else         ifu_req_valid = 1'b0;
        ea = exp_lsu ? laddr : iaddr;
        for (int s = 0; s <= stall; s++) begin
            #1;
            checkOutput("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
            checkOutput("mem_addr", {32'd0, mem_addr}, {32'd0, ea});
            checkOutput("mem_wen", {63'd0, mem_wen}, {63'd0, exp_lsu & wen});
            checkOutput("mem_wmask", {60'd0, mem_wmask}, {60'd0, exp_lsu ? wmask : 4'h0});
            if (exp_lsu) checkOutput("mem_wdata", {32'd0, mem_wdata}, {32'd0, wdata});
            checkOutput("readies_busy", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
            if (s == stall) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        for (int d = 1; d < delay; d++) begin
            #1;
            checkOutput("wait_idle", {60'd0, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid | lsu_rsp_valid}, 64'd0);
            tick();
        end
        e.is_lsu = exp_lsu;
        e.data   = rdata;
        exp_q.push_back(e);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        #1;
        checkOutput("owner_rsp_valid", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, exp_lsu ? 64'd1 : 64'd2);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_addr = 32'h0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
        #1;
        checkOutput("reset_handshakes", {63'd0, ifu_req_ready | lsu_req_ready | mem_req_valid}, 64'd0);
        checkOutput("reset_fields", {mem_addr, 27'd0, mem_wen, mem_wmask}, 64'd0);
        checkOutput("reset_err", {63'd0, err_unexp_rsp}, 64'd0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // IFU alone, response two cycles after acceptance.
        applyStimulus(1, 0, 32'h80000000, 32'h0, 0, 32'h0, 4'h0, 0, 2, 32'h00000413, 0);

        // LSU write with memory stalling for three cycles.
        applyStimulus(0, 1, 32'h0, 32'h80001000, 1, 32'hDEADBEEF, 4'h1, 3, 2, 32'h0, 1);

        // Long LSU read while IFU waits; IFU must be granted right after the response.
        applyStimulus(1, 1, 32'h80000004, 32'h80002000, 0, 32'h0, 4'hF, 0, 10, 32'hCAFEF00D, 1);
        #1;
        checkOutput("ifu_after_lsu", {63'd0, ifu_req_ready}, 64'd1);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        exp_q.push_back('{is_lsu: 1'b0, data: 32'h11110000});
        mem_rsp_valid = 1'b1; mem_rdata = 32'h11110000;
        tick();
        mem_rsp_valid = 1'b0;

        // Contested stream: LSU x4 then a forced IFU, twice.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 32'h80000100 + 32'(i * 4), 32'h80003000 + 32'(i * 4), 0, 32'h0, 4'hF,
                          0, 1, 32'hA0000000 + 32'(i), (i % 5) != 4);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();

        // Spurious response in IDLE is dropped and flagged until reset.
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1234;
        #1;
        checkOutput("spurious_no_fwd", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("err_set", {63'd0, err_unexp_rsp}, 64'd1);
        tick(); tick(); tick();
        checkOutput("err_sticky", {63'd0, err_unexp_rsp}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("err_cleared", {63'd0, err_unexp_rsp}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while waiting for a response.
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000040;
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        checkOutput("rst_wait_outputs",
                    {59'd0, ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        checkOutput("rst_wait_addr", {32'd0, mem_addr}, 64'd0);
        tick();
        rst_n = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1;
        checkOutput("late_rsp_no_fwd", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("late_rsp_err", {63'd0, err_unexp_rsp}, 64'd1);
        tick();
        applyStimulus(1, 0, 32'h80000044, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h00100093, 0);

        tick(); tick();
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
